// File: rtl/cpu_bus_mem.sv
// cpu_bus_mem: windowed, mirrored RAM responder with wait states, write protection and open-bus reads
module cpu_bus_mem #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MEM_AW      = 11,
  parameter int unsigned BASE        = 32'h0000,
  parameter int unsigned SPAN        = 32'h2000,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned RO_OFFSET   = 32'h2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren,
  input  logic              wen,
  input  logic [ADDR_W-1:0] cpu_addr_out,
  input  logic [DATA_W-1:0] cpu_data_out,
  output logic [DATA_W-1:0] cpu_data_in,
  output logic              rdy,
  output logic              wr_prot_err,
  output logic [7:0]        err_count
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;
  state_e state_q;
  logic [3:0] cnt_q;
  logic [ADDR_W-1:0] addr_q, addr_c;
  logic [DATA_W-1:0] wdata_q, wdata_c, data_q;
  logic ren_q, wen_q, ren_c, wen_c;
  logic rdy_q, perr_q;
  logic [7:0] errc_q, errc_d;
  logic [31:0] off;
  logic hit, prot, req, stall, exec, blocked, coll;
  logic [DATA_W-1:0] mem [2**MEM_AW];
  // in IDLE the live bus is decoded; in WAIT the latched request is
  assign addr_c  = state_q == S_IDLE ? cpu_addr_out : addr_q;
  assign wdata_c = state_q == S_IDLE ? cpu_data_out : wdata_q;
  assign ren_c   = state_q == S_IDLE ? ren : ren_q;
  assign wen_c   = state_q == S_IDLE ? wen : wen_q;
  // below-BASE addresses wrap to a huge offset, so one compare decodes the window
  assign off     = 32'(addr_c) - BASE;
  assign hit     = off < SPAN;
  assign prot    = off >= RO_OFFSET;
  assign req     = state_q == S_IDLE && (ren || wen);
  assign stall   = req && hit && WAIT_STATES != 0;
  assign exec    = (req && !stall) || (state_q == S_WAIT && cnt_q == 4'd0);
  assign blocked = wen_c && hit && prot;
  assign coll    = ren_c && wen_c;
  assign errc_d  = errc_q + 8'(exec && (blocked || coll) && errc_q != 8'hFF);
  always_ff @(posedge clk)
    if (!rst && exec && wen_c && hit && !prot) mem[off[MEM_AW-1:0]] <= wdata_c;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b1;
      data_q  <= '0;
      perr_q  <= 1'b0;
      errc_q  <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= stall ? S_WAIT : state_q == S_WAIT ? (cnt_q == 4'd0 ? S_DONE : S_WAIT) : S_IDLE;
      cnt_q   <= stall ? 4'(WAIT_STATES - 1) : cnt_q - 4'(state_q == S_WAIT && cnt_q != 4'd0);
      rdy_q   <= !stall && !(state_q == S_WAIT && cnt_q != 4'd0);
      perr_q  <= exec && blocked;
      errc_q  <= errc_d;
      if (exec && ren_c && !wen_c && hit) data_q <= mem[off[MEM_AW-1:0]];
      if (stall) begin
        addr_q  <= cpu_addr_out;
        wdata_q <= cpu_data_out;
        ren_q   <= ren;
        wen_q   <= wen;
      end
    end
  end
  assign cpu_data_in = data_q;
  assign rdy         = rdy_q;
  assign wr_prot_err = perr_q;
  assign err_count   = errc_q;
endmodule

// File: tb/tb_cpu_bus_mem.sv
// tb_cpu_bus_mem: zero-wait and three-wait responders checked against a table and a behavioural model
module tb_cpu_bus_mem;
  localparam int BASE = 'h0000, SPAN = 'h2000, RO = 'h1000, DEPTH = 2048;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_w [2], ren_w [2], wen_w [2], rdy_w [2], perr_w [2];
  logic [15:0] addr_w [2];
  logic [7:0] wd_w [2], rd_w [2], ec_w [2];
  cpu_bus_mem #(.BASE(BASE), .SPAN(SPAN), .RO_OFFSET(RO), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst_w[0]), .ren(ren_w[0]), .wen(wen_w[0]),
    .cpu_addr_out(addr_w[0]), .cpu_data_out(wd_w[0]), .cpu_data_in(rd_w[0]),
    .rdy(rdy_w[0]), .wr_prot_err(perr_w[0]), .err_count(ec_w[0]));
  cpu_bus_mem #(.BASE(BASE), .SPAN(SPAN), .RO_OFFSET(RO), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst_w[1]), .ren(ren_w[1]), .wen(wen_w[1]),
    .cpu_addr_out(addr_w[1]), .cpu_data_out(wd_w[1]), .cpu_data_in(rd_w[1]),
    .rdy(rdy_w[1]), .wr_prot_err(perr_w[1]), .err_count(ec_w[1]));
  byte unsigned mem_m [2][DEPTH];
  int dat_m [2], err_m [2];
  int n_chk = 0, n_fail = 0;
  typedef struct { bit r; bit w; int a; int d; int e_dat; int e_perr; int e_err; } vec_t;
  vec_t tbl [14];
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // one CPU transaction: the model is advanced from address arithmetic, then the bus is driven and held until rdy
  task automatic access(input int k, input bit r, input bit w, input int a, input int d, input string nm,
                        output int o_dat, output int o_perr, output int o_err);
    int off, idx, low;
    bit hit, blk, coll;
    off  = a - BASE;
    hit  = off >= 0 && off < SPAN;
    idx  = off % DEPTH;
    blk  = w && hit && off >= RO;
    coll = r && w;
    if (w && hit && !blk) mem_m[k][idx] = 8'(d);
    else if (r && !w && hit) dat_m[k] = mem_m[k][idx];
    if ((blk || coll) && err_m[k] < 255) err_m[k]++;
    @(negedge clk);
    ren_w[k] = r; wen_w[k] = w; addr_w[k] = 16'(a); wd_w[k] = 8'(d);
    @(posedge clk); #1;
    low = 0;
    while (!rdy_w[k] && low < 20) begin
      @(posedge clk); #1;
      low++;
    end
    chk({nm, " rdy-low cycles"}, low, (k == 1 && hit) ? 3 : 0);
    chk({nm, " cpu_data_in"}, int'(rd_w[k]), dat_m[k]);
    chk({nm, " wr_prot_err"}, int'(perr_w[k]), int'(blk));
    chk({nm, " err_count"}, int'(ec_w[k]), err_m[k]);
    o_dat = rd_w[k]; o_perr = perr_w[k]; o_err = ec_w[k];
    if (k == 1 && hit) begin
      @(posedge clk); #1;
      chk({nm, " held request in DONE rdy"}, int'(rdy_w[k]), 1);
    end
    ren_w[k] = 1'b0; wen_w[k] = 1'b0;
    @(posedge clk); #1;
    chk({nm, " wr_prot_err pulse end"}, int'(perr_w[k]), 0);
  endtask
  initial begin
    int od, opr, oe, kind, idx, a, op;
    tbl[0]  = '{1'b0, 1'b1, 'h0123, 'hA5, 'h00, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 'h0923, 'h00, 'hA5, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 'h0000, 'h12, 'hA5, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 'h1800, 'h55, 'hA5, 1, 1};
    tbl[4]  = '{1'b1, 1'b0, 'h0000, 'h00, 'h12, 0, 1};
    tbl[5]  = '{1'b0, 1'b1, 'h0010, 'h3C, 'h12, 0, 1};
    tbl[6]  = '{1'b1, 1'b0, 'h0010, 'h00, 'h3C, 0, 1};
    tbl[7]  = '{1'b1, 1'b0, 'h8000, 'h00, 'h3C, 0, 1};
    tbl[8]  = '{1'b0, 1'b1, 'h8000, 'hEE, 'h3C, 0, 1};
    tbl[9]  = '{1'b1, 1'b0, 'h0000, 'h00, 'h12, 0, 1};
    tbl[10] = '{1'b1, 1'b1, 'h0040, 'h77, 'h12, 0, 2};
    tbl[11] = '{1'b1, 1'b0, 'h0040, 'h00, 'h77, 0, 2};
    tbl[12] = '{1'b1, 1'b1, 'h1040, 'h88, 'h77, 1, 3};
    tbl[13] = '{1'b1, 1'b0, 'h0840, 'h00, 'h77, 0, 3};
    for (int k = 0; k < 2; k++) begin
      rst_w[k] = 1'b1; ren_w[k] = 1'b0; wen_w[k] = 1'b0; addr_w[k] = '0; wd_w[k] = '0;
      dat_m[k] = 0; err_m[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset%0d rdy", k), int'(rdy_w[k]), 1);
      chk($sformatf("reset%0d cpu_data_in", k), int'(rd_w[k]), 0);
      chk($sformatf("reset%0d wr_prot_err", k), int'(perr_w[k]), 0);
      chk($sformatf("reset%0d err_count", k), int'(ec_w[k]), 0);
    end
    @(negedge clk);
    rst_w[0] = 1'b0; rst_w[1] = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 14; i++) begin
        access(k, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, $sformatf("tbl%0d.%0d", k, i), od, opr, oe);
        chk($sformatf("tbl%0d.%0d table data", k, i), od, tbl[i].e_dat);
        chk($sformatf("tbl%0d.%0d table perr", k, i), opr, tbl[i].e_perr);
        chk($sformatf("tbl%0d.%0d table errs", k, i), oe, tbl[i].e_err);
      end
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++)
        access(k, 1'b0, 1'b1, i, int'($urandom_range(0, 255)), "prefill", od, opr, oe);
    for (int k = 0; k < 2; k++)
      for (int n = 0; n < 150; n++) begin
        kind = int'($urandom_range(0, 3));
        idx  = int'($urandom_range(0, 15));
        a = kind == 1 ? 'h1000 + 'h800 * int'($urandom_range(0, 1)) + idx :
            kind == 2 ? 'h2000 + int'($urandom_range(0, 'hDFFF)) :
                        'h800 * int'($urandom_range(0, 1)) + idx;
        op = int'($urandom_range(0, kind == 2 ? 1 : 2));
        access(k, op != 1, op != 0, a, int'($urandom_range(0, 255)), $sformatf("rand%0d.%0d", k, n), od, opr, oe);
      end
    access(1, 1'b0, 1'b1, 'h0050, 'h11, "abort pre", od, opr, oe);
    @(negedge clk);
    wen_w[1] = 1'b1; addr_w[1] = 16'h0050; wd_w[1] = 8'h99;
    @(posedge clk); #1;
    chk("abort accepted rdy", int'(rdy_w[1]), 0);
    @(negedge clk);
    rst_w[1] = 1'b1;
    @(posedge clk); #1;
    chk("abort rdy", int'(rdy_w[1]), 1);
    chk("abort cpu_data_in", int'(rd_w[1]), 0);
    chk("abort err_count", int'(ec_w[1]), 0);
    chk("abort wr_prot_err", int'(perr_w[1]), 0);
    rst_w[1] = 1'b0; wen_w[1] = 1'b0;
    dat_m[1] = 0; err_m[1] = 0;
    repeat (4) @(posedge clk);
    access(1, 1'b1, 1'b0, 'h0050, 0, "abort post read", od, opr, oe);
    chk("abort RAM unchanged", od, 'h11);
    for (int n = 0; n < 300; n++)
      access(0, 1'b1, 1'b1, 'h0040, 'h77, "collide", od, opr, oe);
    chk("saturated err_count", int'(ec_w[0]), 255);
    access(0, 1'b1, 1'b0, 'h0040, 0, "collide read", od, opr, oe);
    chk("collision write data", od, 'h77);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
